// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side byte buffer behind the UART receiver.
// Captures each byte or framing error from the UART hold-until-ack interface,
// pulses rx_ack, and stores {ferr, data} in a show-ahead FIFO that is popped
// by the register interface.
//
// Ports:
//   clk       system clock
//   resetn    synchronous reset, active-high (asserted = 1)
//   rx_data   byte from the UART receiver, valid while rx_avail = 1
//   rx_avail  UART byte ready, held until acknowledged
//   rx_error  UART bad stop bit, held until acknowledged
//   rx_ack    one-cycle acknowledge to the UART (registered)
//   rd_en     pop request
//   rd_data   head-entry byte (0 when empty)
//   rd_ferr   head-entry framing-error flag (0 when empty)
//   empty     FIFO holds no entries
//   full      FIFO holds 2^DEPTH_LOG2 entries
//   level     number of stored entries
//   overrun   sticky: a received entry was dropped
//   clr_ovr   clears overrun (a same-cycle drop wins)
module uart_rx_fifo #(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [7:0]            rx_data,
    input  logic                  rx_avail,
    input  logic                  rx_error,
    output logic                  rx_ack,
    input  logic                  rd_en,
    output logic [7:0]            rd_data,
    output logic                  rd_ferr,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overrun,
    input  logic                  clr_ovr
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned LW    = DEPTH_LOG2 + 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_ACK  = 1'b1;

    logic [0:0]            state_q, state_d;
    logic                  ack_q, ack_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         level_q, level_d;
    logic                  ovr_q, ovr_d;
    logic [8:0]            mem_q [DEPTH];

    logic                  push_try;
    logic                  push_ok;
    logic                  pop;
    logic                  empty_c;
    logic [8:0]            entry;
    logic [8:0]            head;

    assign empty_c = (level_q == '0);

    // Capture FSM: sample the UART flags in IDLE, acknowledge in ACK.
    always_comb begin
        state_d  = state_q;
        ack_d    = 1'b0;
        push_try = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rx_avail || rx_error) begin
                    push_try = 1'b1;
                    ack_d    = 1'b1;
                    state_d  = S_ACK;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FIFO bookkeeping; a pop in the same cycle frees the slot for a push at full.
    always_comb begin
        pop      = rd_en && !empty_c;
        push_ok  = push_try && ((level_q < LW'(DEPTH)) || pop);
        // rx_data is stale on a framing error, so store zero data.
        entry    = rx_error ? 9'h100 : {1'b0, rx_data};
        wr_ptr_d = push_ok ? wr_ptr_q + DEPTH_LOG2'(1) : wr_ptr_q;
        rd_ptr_d = pop     ? rd_ptr_q + DEPTH_LOG2'(1) : rd_ptr_q;
        level_d  = level_q;
        if (push_ok && !pop) begin
            level_d = level_q + LW'(1);
        end else if (!push_ok && pop) begin
            level_d = level_q - LW'(1);
        end
        ovr_d = ovr_q;
        if (push_try && !push_ok) begin
            ovr_d = 1'b1;
        end else if (clr_ovr) begin
            ovr_d = 1'b0;
        end
    end

    // Control state, pointers and flags.
    always_ff @(posedge clk) begin
        if (resetn) begin
            state_q  <= S_IDLE;
            ack_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ack_q    <= ack_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovr_q    <= ovr_d;
        end
    end

    // Entry storage; contents need no reset because level gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok && !resetn) begin
            mem_q[wr_ptr_q] <= entry;
        end
    end

    assign head    = mem_q[rd_ptr_q];
    assign rd_data = empty_c ? 8'h00 : head[7:0];
    assign rd_ferr = empty_c ? 1'b0  : head[8];
    assign empty   = empty_c;
    assign full    = (level_q == LW'(DEPTH));
    assign level   = level_q;
    assign overrun = ovr_q;
    assign rx_ack  = ack_q;

endmodule
